// File: rtl/char_motion_hp.sv
// Per-player character core: frame-rate walk/jump/gravity motion, screen clamping, health, iframes, knockback.
// Optional feature macro: CHAR_DOUBLE_JUMP_EN (one extra mid-air jump on a stepjump rising edge).
module char_motion_hp #(
   parameter int X_INIT    = 100,
   parameter int Y_INIT    = 500,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = 960,
   parameter int Y_FLOOR   = 560,
   parameter int WALK_STEP = 4,
   parameter int JUMP_V    = 12,
   parameter int GRAVITY   = 1,
   parameter int VMAX      = 15,
   parameter int HP_MAX    = 4,
   parameter int IFRAMES   = 60,
   parameter int KNOCK     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic [1:0]  game_active,
   input  logic        game_start,
   input  logic        stepleft,
   input  logic        stepright,
   input  logic        stepjump,
   input  logic        on_ground,
   input  logic        hit_valid,
   input  logic [3:0]  hit_dmg,
   input  logic        hit_from_left,
   output logic [11:0] pos_x,
   output logic [11:0] pos_y,
   output logic        flip_h,
   output logic [3:0]  current_health,
   output logic        invuln,
   output logic        dead,
   output logic [1:0]  state
);
   localparam int CNT_W = (IFRAMES < 2) ? 1 : $clog2(IFRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IFRAMES);
   localparam logic signed [12:0] X_MIN_S   = 13'(X_MIN);
   localparam logic signed [12:0] X_MAX_S   = 13'(X_MAX);
   localparam logic signed [12:0] Y_FLOOR_S = 13'(Y_FLOOR);
   localparam logic signed [12:0] WALK_S    = 13'(WALK_STEP);
   localparam logic signed [12:0] KNOCK_S   = 13'(KNOCK);
   localparam logic signed [12:0] GRAV_S    = 13'(GRAVITY);
   localparam logic signed [12:0] VMAX_S    = 13'(VMAX);
   localparam logic signed [7:0]  JUMP_VY   = 8'(-JUMP_V);

   typedef enum logic [1:0] {
      ST_GROUND = 2'b00,
      ST_RISE   = 2'b01,
      ST_FALL   = 2'b10,
      ST_DEAD   = 2'b11
   } state_t;

   state_t             state_r, state_s;
   logic [11:0]        pos_x_r, pos_x_s, pos_y_r, pos_y_s;
   logic signed [7:0]  vy_r, vy_s;
   logic               flip_h_r, flip_h_s;
   logic [3:0]         health_r, health_s;
   logic [CNT_W-1:0]   icnt_r, icnt_s;
   logic               invuln_r, invuln_s;
   logic               dead_r, dead_s;
   logic               play_s, hit_acc_s, fatal_s, mot_s;
   logic signed [12:0] x_cur_s, y_cur_s, vy_ext_s, y_sum_s, vy_grav_s;
`ifdef CHAR_DOUBLE_JUMP_EN
   logic               jump_prev_r, jump_prev_s, credit_r, credit_s, jump_edge_s;
`endif

   function automatic logic [11:0] clamp_x(input logic signed [12:0] v);
      logic [11:0] r;
      if (v < X_MIN_S) r = 12'(X_MIN);
      else if (v > X_MAX_S) r = 12'(X_MAX);
      else r = v[11:0];
      return r;
   endfunction

   function automatic logic [11:0] clip_top(input logic signed [12:0] v);
      logic [11:0] r;
      if (v < 13'sd0) r = 12'd0;
      else r = v[11:0];
      return r;
   endfunction

   // Next-state logic for motion, health and invulnerability; game_start overrides everything.
   always_comb begin
      state_s   = state_r;
      pos_x_s   = pos_x_r;
      pos_y_s   = pos_y_r;
      vy_s      = vy_r;
      flip_h_s  = flip_h_r;
      health_s  = health_r;
      icnt_s    = icnt_r;
      dead_s    = dead_r;
`ifdef CHAR_DOUBLE_JUMP_EN
      jump_prev_s = jump_prev_r;
      credit_s    = credit_r;
      jump_edge_s = stepjump && !jump_prev_r;
`endif
      play_s    = (game_active == 2'd1);
      hit_acc_s = play_s && hit_valid && !dead_r && (icnt_r == CNT_ZERO);
      fatal_s   = hit_acc_s && (hit_dmg >= health_r);
      mot_s     = play_s && frame_tick && (state_r != ST_DEAD);
      x_cur_s   = $signed({1'b0, pos_x_r});
      y_cur_s   = $signed({1'b0, pos_y_r});
      vy_ext_s  = {{5{vy_r[7]}}, vy_r};
      y_sum_s   = y_cur_s + vy_ext_s;
      vy_grav_s = vy_ext_s + GRAV_S;

      if (game_start) begin
         state_s  = ST_FALL;
         pos_x_s  = 12'(X_INIT);
         pos_y_s  = 12'(Y_INIT);
         vy_s     = 8'sd0;
         flip_h_s = 1'b0;
         health_s = 4'(HP_MAX);
         icnt_s   = CNT_ZERO;
         dead_s   = 1'b0;
`ifdef CHAR_DOUBLE_JUMP_EN
         jump_prev_s = 1'b0;
         credit_s    = 1'b1;
`endif
      end else begin
         if (hit_acc_s) begin
            health_s = fatal_s ? 4'd0 : (health_r - hit_dmg);
            icnt_s   = CNT_LOAD;
            pos_x_s  = clamp_x(hit_from_left ? (x_cur_s + KNOCK_S) : (x_cur_s - KNOCK_S));
            if (fatal_s) begin
               dead_s  = 1'b1;
               state_s = ST_DEAD;
            end else begin
               dead_s  = dead_r;
            end
         end else if (play_s && frame_tick && (icnt_r != CNT_ZERO)) begin
            icnt_s = icnt_r - CNT_ONE;
         end else begin
            icnt_s = icnt_r;
         end

         if (mot_s && !fatal_s) begin
`ifdef CHAR_DOUBLE_JUMP_EN
            jump_prev_s = stepjump;
`endif
            // Knockback already owns the x update when a hit lands on this frame.
            if (!hit_acc_s) begin
               if (stepleft && !stepright) begin
                  pos_x_s  = clamp_x(x_cur_s - WALK_S);
                  flip_h_s = 1'b1;
               end else if (stepright && !stepleft) begin
                  pos_x_s  = clamp_x(x_cur_s + WALK_S);
                  flip_h_s = 1'b0;
               end else begin
                  flip_h_s = flip_h_r;
               end
            end else begin
               flip_h_s = flip_h_r;
            end

            case (state_r)
               ST_GROUND: begin
`ifdef CHAR_DOUBLE_JUMP_EN
                  credit_s = 1'b1;
`endif
                  if (stepjump) begin
                     vy_s    = JUMP_VY;
                     state_s = ST_RISE;
                  end else if (!on_ground) begin
                     vy_s    = 8'sd0;
                     state_s = ST_FALL;
                  end else begin
                     vy_s    = 8'sd0;
                  end
               end
               ST_RISE: begin
`ifdef CHAR_DOUBLE_JUMP_EN
                  if (jump_edge_s && credit_r) begin
                     vy_s     = JUMP_VY;
                     credit_s = 1'b0;
                  end else
`endif
                  if (y_sum_s < 13'sd0) begin
                     pos_y_s = 12'd0;
                     vy_s    = 8'sd0;
                     state_s = ST_FALL;
                  end else begin
                     pos_y_s = y_sum_s[11:0];
                     vy_s    = vy_grav_s[7:0];
                     state_s = (vy_grav_s >= 13'sd0) ? ST_FALL : ST_RISE;
                  end
               end
               ST_FALL: begin
`ifdef CHAR_DOUBLE_JUMP_EN
                  if (jump_edge_s && credit_r) begin
                     vy_s     = JUMP_VY;
                     credit_s = 1'b0;
                     state_s  = ST_RISE;
                  end else
`endif
                  if (on_ground || (y_sum_s >= Y_FLOOR_S)) begin
                     pos_y_s = (y_sum_s > Y_FLOOR_S) ? 12'(Y_FLOOR) : clip_top(y_sum_s);
                     vy_s    = 8'sd0;
                     state_s = ST_GROUND;
`ifdef CHAR_DOUBLE_JUMP_EN
                     credit_s = 1'b1;
`endif
                  end else begin
                     pos_y_s = clip_top(y_sum_s);
                     vy_s    = (vy_grav_s > VMAX_S) ? 8'(VMAX) : vy_grav_s[7:0];
                  end
               end
               default: begin
                  state_s = state_r;
               end
            endcase
         end else begin
            state_s = state_s;
         end
      end
      invuln_s = (icnt_s != CNT_ZERO);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_FALL;
         pos_x_r  <= 12'(X_INIT);
         pos_y_r  <= 12'(Y_INIT);
         vy_r     <= 8'sd0;
         flip_h_r <= 1'b0;
         health_r <= 4'(HP_MAX);
         icnt_r   <= CNT_ZERO;
         invuln_r <= 1'b0;
         dead_r   <= 1'b0;
`ifdef CHAR_DOUBLE_JUMP_EN
         jump_prev_r <= 1'b0;
         credit_r    <= 1'b1;
`endif
      end else begin
         state_r  <= state_s;
         pos_x_r  <= pos_x_s;
         pos_y_r  <= pos_y_s;
         vy_r     <= vy_s;
         flip_h_r <= flip_h_s;
         health_r <= health_s;
         icnt_r   <= icnt_s;
         invuln_r <= invuln_s;
         dead_r   <= dead_s;
`ifdef CHAR_DOUBLE_JUMP_EN
         jump_prev_r <= jump_prev_s;
         credit_r    <= credit_s;
`endif
      end
   end

   assign pos_x          = pos_x_r;
   assign pos_y          = pos_y_r;
   assign flip_h         = flip_h_r;
   assign current_health = health_r;
   assign invuln         = invuln_r;
   assign dead           = dead_r;
   assign state          = state_r;
endmodule

// File: tb/tb_char_motion_hp.sv
// Directed self-checking bench for char_motion_hp (default parameters).
module tb_char_motion_hp;
   logic        clk = 1'b0;
   logic        rst, frame_tick, game_start, stepleft, stepright, stepjump, on_ground;
   logic        hit_valid, hit_from_left;
   logic [1:0]  game_active;
   logic [3:0]  hit_dmg;
   logic [11:0] pos_x, pos_y;
   logic        flip_h, invuln, dead;
   logic [3:0]  current_health;
   logic [1:0]  state;
   int errors = 0;
   int checks = 0;

   char_motion_hp dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
      .game_start(game_start), .stepleft(stepleft), .stepright(stepright),
      .stepjump(stepjump), .on_ground(on_ground), .hit_valid(hit_valid),
      .hit_dmg(hit_dmg), .hit_from_left(hit_from_left), .pos_x(pos_x), .pos_y(pos_y),
      .flip_h(flip_h), .current_health(current_health), .invuln(invuln),
      .dead(dead), .state(state)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         @(posedge clk); #1;
         frame_tick = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic hit(input logic [3:0] dmg, input logic from_left);
      hit_dmg = dmg; hit_from_left = from_left; hit_valid = 1'b1;
      @(posedge clk); #1;
      hit_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; frame_tick = 1'b0; game_active = 2'd1; game_start = 1'b0;
      stepleft = 1'b0; stepright = 1'b0; stepjump = 1'b0; on_ground = 1'b1;
      hit_valid = 1'b0; hit_dmg = 4'd0; hit_from_left = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (state !== 2'b10) begin errors++; $display("FAIL reset_state: got %b want 10", state); end
      checks++; if (dead !== 1'b0 || invuln !== 1'b0) begin errors++; $display("FAIL reset_flags: dead=%b invuln=%b want 0 0", dead, invuln); end
      tick(1);
      checks++; if (pos_x !== 12'd100 || pos_y !== 12'd500) begin errors++; $display("FAIL reset_pos: got (%0d,%0d) want (100,500)", pos_x, pos_y); end
      checks++; if (current_health !== 4'd4) begin errors++; $display("FAIL reset_health: got %0d want 4", current_health); end
      checks++; if (state !== 2'b00 || flip_h !== 1'b0) begin errors++; $display("FAIL reset_ground: state=%b flip=%b want 00 0", state, flip_h); end
   endtask

   task automatic test_walk();
      stepright = 1'b1; tick(10);
      checks++; if (pos_x !== 12'd140 || flip_h !== 1'b0) begin errors++; $display("FAIL walk_right: x=%0d flip=%b want 140 0", pos_x, flip_h); end
      stepright = 1'b0; stepleft = 1'b1; tick(36);
      checks++; if (pos_x !== 12'd0 || flip_h !== 1'b1) begin errors++; $display("FAIL clamp_left: x=%0d flip=%b want 0 1", pos_x, flip_h); end
      stepleft = 1'b0; stepright = 1'b1; tick(245);
      checks++; if (pos_x !== 12'd960 || flip_h !== 1'b0) begin errors++; $display("FAIL clamp_right: x=%0d flip=%b want 960 0", pos_x, flip_h); end
      stepright = 1'b0; stepleft = 1'b1; tick(215);
      stepright = 1'b1; tick(1);
      checks++; if (pos_x !== 12'd100 || flip_h !== 1'b1) begin errors++; $display("FAIL walk_both: x=%0d flip=%b want 100 1", pos_x, flip_h); end
      stepleft = 1'b0; stepright = 1'b0;
   endtask

   task automatic test_jump();
      stepjump = 1'b1; tick(1);
      checks++; if (state !== 2'b01 || pos_y !== 12'd500) begin errors++; $display("FAIL jump_start: state=%b y=%0d want 01 500", state, pos_y); end
      stepjump = 1'b0; on_ground = 1'b0; tick(1);
      checks++; if (pos_y !== 12'd488) begin errors++; $display("FAIL jump_y1: got %0d want 488", pos_y); end
      tick(1);
      checks++; if (pos_y !== 12'd477) begin errors++; $display("FAIL jump_y2: got %0d want 477", pos_y); end
      tick(9);
      checks++; if (pos_y !== 12'd423 || state !== 2'b01) begin errors++; $display("FAIL jump_pre_apex: y=%0d state=%b want 423 01", pos_y, state); end
      tick(1);
      checks++; if (pos_y !== 12'd422 || state !== 2'b10) begin errors++; $display("FAIL jump_apex: y=%0d state=%b want 422 10", pos_y, state); end
      tick(3);
      checks++; if (pos_y !== 12'd425) begin errors++; $display("FAIL fall_y: got %0d want 425", pos_y); end
      on_ground = 1'b1; tick(1);
      checks++; if (pos_y !== 12'd428 || state !== 2'b00) begin errors++; $display("FAIL land: y=%0d state=%b want 428 00", pos_y, state); end
      on_ground = 1'b0; tick(3);
      checks++; if (pos_y !== 12'd429 || state !== 2'b10) begin errors++; $display("FAIL walk_off_vy0: y=%0d state=%b want 429 10", pos_y, state); end
      on_ground = 1'b1; tick(1);
      on_ground = 1'b0; tick(17);
      checks++; if (pos_y !== 12'd551 || state !== 2'b10) begin errors++; $display("FAIL long_fall: y=%0d state=%b want 551 10", pos_y, state); end
      tick(1);
      checks++; if (pos_y !== 12'd560 || state !== 2'b00) begin errors++; $display("FAIL floor_clamp: y=%0d state=%b want 560 00", pos_y, state); end
      on_ground = 1'b1;
   endtask

   task automatic test_hit();
      hit(4'd1, 1'b1);
      checks++; if (current_health !== 4'd3 || pos_x !== 12'd116 || invuln !== 1'b1) begin errors++; $display("FAIL hit_first: hp=%0d x=%0d inv=%b want 3 116 1", current_health, pos_x, invuln); end
      repeat (4) @(posedge clk);
      #1 hit(4'd1, 1'b1);
      checks++; if (current_health !== 4'd3 || pos_x !== 12'd116) begin errors++; $display("FAIL hit_dropped: hp=%0d x=%0d want 3 116", current_health, pos_x); end
      tick(59);
      checks++; if (invuln !== 1'b1) begin errors++; $display("FAIL iframes_hold: got %b want 1", invuln); end
      tick(1);
      checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL iframes_end: got %b want 0", invuln); end
   endtask

   task automatic test_same_cycle();
      stepright = 1'b1; frame_tick = 1'b1;
      hit_dmg = 4'd1; hit_from_left = 1'b0; hit_valid = 1'b1;
      @(posedge clk); #1;
      hit_valid = 1'b0; frame_tick = 1'b0; stepright = 1'b0;
      checks++; if (pos_x !== 12'd100 || current_health !== 4'd2) begin errors++; $display("FAIL knock_vs_walk: x=%0d hp=%0d want 100 2", pos_x, current_health); end
      tick(60);
      checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL iframes_end2: got %b want 0", invuln); end
   endtask

   task automatic test_freeze();
      game_active = 2'd2; stepright = 1'b1;
      tick(3);
      hit(4'd1, 1'b1);
      checks++; if (pos_x !== 12'd100 || current_health !== 4'd2 || invuln !== 1'b0) begin errors++; $display("FAIL freeze: x=%0d hp=%0d inv=%b want 100 2 0", pos_x, current_health, invuln); end
      game_active = 2'd1; stepright = 1'b0;
   endtask

   task automatic test_death();
      hit(4'd9, 1'b1);
      checks++; if (current_health !== 4'd0 || dead !== 1'b1 || state !== 2'b11) begin errors++; $display("FAIL death: hp=%0d dead=%b state=%b want 0 1 11", current_health, dead, state); end
      checks++; if (pos_x !== 12'd116) begin errors++; $display("FAIL death_knock: x=%0d want 116", pos_x); end
      stepright = 1'b1; on_ground = 1'b0; tick(3);
      hit(4'd1, 1'b0);
      checks++; if (pos_x !== 12'd116 || pos_y !== 12'd560 || state !== 2'b11) begin errors++; $display("FAIL dead_frozen: x=%0d y=%0d state=%b want 116 560 11", pos_x, pos_y, state); end
      stepright = 1'b0; on_ground = 1'b1;
   endtask

   task automatic test_respawn();
      game_start = 1'b1;
      @(posedge clk); #1;
      game_start = 1'b0;
      checks++; if (pos_x !== 12'd100 || pos_y !== 12'd500 || current_health !== 4'd4) begin errors++; $display("FAIL respawn: x=%0d y=%0d hp=%0d want 100 500 4", pos_x, pos_y, current_health); end
      checks++; if (dead !== 1'b0 || state !== 2'b10 || invuln !== 1'b0 || flip_h !== 1'b0) begin errors++; $display("FAIL respawn_flags: dead=%b state=%b inv=%b flip=%b want 0 10 0 0", dead, state, invuln, flip_h); end
      game_start = 1'b1; frame_tick = 1'b1; stepleft = 1'b1;
      hit_dmg = 4'd2; hit_from_left = 1'b1; hit_valid = 1'b1;
      @(posedge clk); #1;
      game_start = 1'b0; frame_tick = 1'b0; stepleft = 1'b0; hit_valid = 1'b0;
      checks++; if (pos_x !== 12'd100 || current_health !== 4'd4 || invuln !== 1'b0) begin errors++; $display("FAIL start_priority: x=%0d hp=%0d inv=%b want 100 4 0", pos_x, current_health, invuln); end
   endtask

   task automatic test_double_jump();
      tick(1);
      stepjump = 1'b1; tick(1);
      on_ground = 1'b0; tick(12);
      checks++; if (pos_y !== 12'd422 || state !== 2'b10) begin errors++; $display("FAIL dj_apex: y=%0d state=%b want 422 10", pos_y, state); end
      stepjump = 1'b0; tick(1);
      stepjump = 1'b1; tick(1);
`ifdef CHAR_DOUBLE_JUMP_EN
      checks++; if (state !== 2'b01 || pos_y !== 12'd422) begin errors++; $display("FAIL second_jump: state=%b y=%0d want 01 422", state, pos_y); end
`else
      checks++; if (state !== 2'b10 || pos_y !== 12'd423) begin errors++; $display("FAIL second_jump: state=%b y=%0d want 10 423", state, pos_y); end
`endif
      stepjump = 1'b0; tick(1);
      stepjump = 1'b1; tick(1);
`ifdef CHAR_DOUBLE_JUMP_EN
      checks++; if (state !== 2'b01 || pos_y !== 12'd399) begin errors++; $display("FAIL third_jump: state=%b y=%0d want 01 399", state, pos_y); end
`else
      checks++; if (state !== 2'b10 || pos_y !== 12'd428) begin errors++; $display("FAIL third_jump: state=%b y=%0d want 10 428", state, pos_y); end
`endif
      stepjump = 1'b0; on_ground = 1'b1;
   endtask

   initial begin
      test_reset();
      test_walk();
      test_jump();
      test_hit();
      test_same_cycle();
      test_freeze();
      test_death();
      test_respawn();
      test_double_jump();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
